// File: rtl/bist_session_ctrl.sv
// Sequencer for one signature-based BIST session: resets the CUT/MISR, walks the pattern
// memory with a programmable settle time, compacts once per pattern and checks the signature.
module bist_session_ctrl #(
    parameter int OUT_W        = 14,
    parameter int ADDR_W       = 8,
    parameter int NUM_PATTERNS = 225,
    parameter int SETTLE       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [OUT_W-1:0]  golden_sig,
    input  logic [OUT_W-1:0]  misr_sig,
    input  logic [OUT_W-1:0]  cut_out,
    input  logic [OUT_W-1:0]  gold_out,
    output logic [ADDR_W-1:0] pat_addr,
    output logic              pat_valid,
    output logic              cut_reset,
    output logic              misr_clr,
    output logic              misr_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              mismatch,
    output logic [ADDR_W-1:0] first_fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_APPLY,
        S_CAPTURE,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_PATTERNS - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    settle_q, settle_d;
    logic [ADDR_W-1:0]   pat_addr_q, pat_addr_d;
    logic                mismatch_q, mismatch_d;
    logic [ADDR_W-1:0]   first_fail_q, first_fail_d;
    logic                pass_q, pass_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            settle_q     <= '0;
            pat_addr_q   <= '0;
            mismatch_q   <= 1'b0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            pat_addr_q   <= pat_addr_d;
            mismatch_q   <= mismatch_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        pat_addr_d   = pat_addr_q;
        mismatch_d   = mismatch_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                state_d      = S_APPLY;
                settle_d     = '0;
                pat_addr_d   = '0;
                mismatch_d   = 1'b0;
                first_fail_d = '0;
                pass_d       = 1'b0;
            end
            S_APPLY: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    settle_d = settle_q + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                // Only the first failing pattern is recorded for the fault dictionary.
                if ((cut_out != gold_out) && !mismatch_q) begin
                    mismatch_d   = 1'b1;
                    first_fail_d = pat_addr_q;
                end
                if (pat_addr_q == LAST_ADDR) begin
                    state_d = S_COMPARE;
                end else begin
                    state_d    = S_APPLY;
                    pat_addr_d = pat_addr_q + ADDR_W'(1);
                    settle_d   = '0;
                end
            end
            S_COMPARE: begin
                pass_d  = (misr_sig == golden_sig);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_CLR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            settle_d     = '0;
            pat_addr_d   = '0;
            mismatch_d   = 1'b0;
            first_fail_d = '0;
            pass_d       = 1'b0;
        end
    end

    always_comb begin
        cut_reset = (state_q == S_CLR);
        misr_clr  = (state_q == S_CLR);
        pat_valid = (state_q == S_APPLY) || (state_q == S_CAPTURE);
        misr_en   = (state_q == S_CAPTURE);
        busy      = (state_q == S_CLR) || (state_q == S_APPLY) ||
                    (state_q == S_CAPTURE) || (state_q == S_COMPARE);
        done      = (state_q == S_DONE);
    end

    assign pat_addr   = pat_addr_q;
    assign mismatch   = mismatch_q;
    assign first_fail = first_fail_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_bist_session_ctrl.sv
// Scoreboard bench for bist_session_ctrl with a 4-pattern, settle-2 session.
module tb_bist_session_ctrl;

   localparam int OUT_W = 14;
   localparam int ADDR_W = 8;
   localparam int NUM_PATTERNS = 4;
   localparam int SETTLE = 2;
   localparam logic [OUT_W-1:0] MISR_VAL = 14'h2C3A;

   logic clk;
   logic reset;
   logic start;
   logic abort;
   logic [OUT_W-1:0] golden_sig;
   logic [OUT_W-1:0] misr_sig;
   logic [OUT_W-1:0] cut_out;
   logic [OUT_W-1:0] gold_out;
   logic [ADDR_W-1:0] pat_addr;
   logic pat_valid;
   logic cut_reset;
   logic misr_clr;
   logic misr_en;
   logic busy;
   logic done;
   logic pass;
   logic mismatch;
   logic [ADDR_W-1:0] first_fail;

   logic [3:0] failMask;

   typedef struct {
      logic expPass;
      logic expMismatch;
      logic [ADDR_W-1:0] expFirstFail;
      int expDoneEdge;
      int expPulses;
   } expect_t;

   expect_t scoreboard[$];

   int testsRun = 0;
   int testsFailed = 0;
   int edgeCount = 0;
   int sessEdge0 = 0;
   bit sessActive = 0;
   bit newSess = 0;
   int pulseIdx = 0;
   logic donePrev = 1'b0;

   bist_session_ctrl #(
      .OUT_W(OUT_W),
      .ADDR_W(ADDR_W),
      .NUM_PATTERNS(NUM_PATTERNS),
      .SETTLE(SETTLE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .abort(abort),
      .golden_sig(golden_sig),
      .misr_sig(misr_sig),
      .cut_out(cut_out),
      .gold_out(gold_out),
      .pat_addr(pat_addr),
      .pat_valid(pat_valid),
      .cut_reset(cut_reset),
      .misr_clr(misr_clr),
      .misr_en(misr_en),
      .busy(busy),
      .done(done),
      .pass(pass),
      .mismatch(mismatch),
      .first_fail(first_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The CUT model: golden outputs depend on the address, the CUT deviates where failMask says.
   always_comb begin
      gold_out = 14'h01A5 ^ {6'b0, pat_addr};
      cut_out = gold_out ^ {13'b0, failMask[pat_addr[1:0]]};
   end

   assign misr_sig = MISR_VAL;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Edge 0 of a session is the rising edge that samples start while no session is tracked.
   always @(posedge clk) begin
      edgeCount++;
      if (start && !sessActive && reset) begin
         sessEdge0 = edgeCount;
         sessActive = 1;
         newSess = 1;
      end
   end

   // Monitor: checks each misr_en pulse position and pops the scoreboard whenever done rises.
   always @(negedge clk) begin
      expect_t e;
      if (newSess) begin
         pulseIdx = 0;
         newSess = 0;
      end
      if (sessActive && misr_en) begin
         checkOutput("misr_en_edge", edgeCount - sessEdge0, (SETTLE + 1) * (pulseIdx + 1));
         pulseIdx++;
      end
      if (done && !donePrev) begin
         if (scoreboard.size() == 0) begin
            checkOutput("sb_unexpected_done", 1, 0);
         end else begin
            e = scoreboard.pop_front();
            checkOutput("done_edge", edgeCount - sessEdge0, e.expDoneEdge);
            checkOutput("pass", {31'b0, pass}, {31'b0, e.expPass});
            checkOutput("mismatch", {31'b0, mismatch}, {31'b0, e.expMismatch});
            checkOutput("first_fail", {24'b0, first_fail}, {24'b0, e.expFirstFail});
            checkOutput("misr_en_count", pulseIdx, e.expPulses);
         end
         sessActive = 0;
      end
      donePrev = done;
   end

   task automatic pushExpect(input logic ePass, input logic eMis, input logic [ADDR_W-1:0] eFf);
      expect_t e;
      e.expPass = ePass;
      e.expMismatch = eMis;
      e.expFirstFail = eFf;
      e.expDoneEdge = 14;
      e.expPulses = 4;
      scoreboard.push_back(e);
   endtask

   task automatic applyStimulus(input logic [3:0] mask, input logic badSig, input bit expectDone,
                                input logic ePass, input logic eMis, input logic [ADDR_W-1:0] eFf);
      failMask = mask;
      golden_sig = badSig ? (MISR_VAL ^ 14'h0010) : MISR_VAL;
      if (expectDone) pushExpect(ePass, eMis, eFf);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone(input string name);
      bit seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) checkOutput(name, 0, 1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_pat_addr"}, {24'b0, pat_addr}, 0);
      checkOutput({tag, "_pat_valid"}, {31'b0, pat_valid}, 0);
      checkOutput({tag, "_cut_reset"}, {31'b0, cut_reset}, 0);
      checkOutput({tag, "_misr_clr"}, {31'b0, misr_clr}, 0);
      checkOutput({tag, "_misr_en"}, {31'b0, misr_en}, 0);
      checkOutput({tag, "_busy"}, {31'b0, busy}, 0);
      checkOutput({tag, "_done"}, {31'b0, done}, 0);
      checkOutput({tag, "_pass"}, {31'b0, pass}, 0);
      checkOutput({tag, "_mismatch"}, {31'b0, mismatch}, 0);
      checkOutput({tag, "_first_fail"}, {24'b0, first_fail}, 0);
   endtask

   initial begin
      bit found;
      reset = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      failMask = 4'b0000;
      golden_sig = MISR_VAL;
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      reset = 1'b1;
      @(negedge clk);
      checkAllZero("idle");

      $display("[TB] clean session");
      applyStimulus(4'b0000, 1'b0, 1, 1'b1, 1'b0, 8'd0);
      waitDone("timeout_clean");
      repeat (3) @(negedge clk);
      checkOutput("done_held", {31'b0, done}, 1);
      checkOutput("pass_held", {31'b0, pass}, 1);

      $display("[TB] mismatches at patterns 2 and 3");
      applyStimulus(4'b1100, 1'b0, 1, 1'b1, 1'b1, 8'd2);
      waitDone("timeout_mismatch");

      $display("[TB] bad golden signature");
      applyStimulus(4'b0000, 1'b1, 1, 1'b0, 1'b0, 8'd0);
      waitDone("timeout_badsig");

      $display("[TB] abort during pattern 1 apply");
      applyStimulus(4'b0001, 1'b0, 0, 1'b0, 1'b0, 8'd0);
      found = 0;
      for (int i = 0; i < 50; i++) begin
         if (pat_addr == 8'd1 && pat_valid && !misr_en) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("abort_reach_apply1", {31'b0, found}, 1);
      checkOutput("abort_pre_mismatch", {31'b0, mismatch}, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      sessActive = 0;
      checkAllZero("abort");
      applyStimulus(4'b0000, 1'b0, 1, 1'b1, 1'b0, 8'd0);
      waitDone("timeout_after_abort");

      $display("[TB] async reset during capture");
      applyStimulus(4'b0001, 1'b0, 0, 1'b0, 1'b0, 8'd0);
      found = 0;
      for (int i = 0; i < 50; i++) begin
         if (pat_addr == 8'd1 && misr_en) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      checkOutput("reset_reach_capture1", {31'b0, found}, 1);
      #1;
      reset = 1'b0;
      sessActive = 0;
      #1;
      checkAllZero("async_reset");
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      checkAllZero("post_reset_idle");

      $display("[TB] start held high");
      failMask = 4'b0000;
      golden_sig = MISR_VAL;
      pushExpect(1'b1, 1'b0, 8'd0);
      pushExpect(1'b1, 1'b0, 8'd0);
      @(negedge clk);
      start = 1'b1;
      waitDone("timeout_held1");
      @(negedge clk);
      checkOutput("restart_cut_reset", {31'b0, cut_reset}, 1);
      checkOutput("restart_misr_clr", {31'b0, misr_clr}, 1);
      checkOutput("restart_done", {31'b0, done}, 0);
      checkOutput("restart_busy", {31'b0, busy}, 1);
      waitDone("timeout_held2");
      start = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("held_done_stays", {31'b0, done}, 1);

      checkOutput("sb_drained", scoreboard.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

endmodule
